ext_arb: RTL and testbench

- Shares one immediate extender among NREQ requesters (decode stage, branch unit, test/debug port, ...).
- Round-robin arbitration, valid/ready handshake on both sides, and one registered result slot.
- Sits between the instruction-field producers and the single `ext` instance in the datapath.
- Delivers the 32-bit extended value tagged with the requester ID.

---
 rtl/ext_pkg.sv | 26 ++
 rtl/ext.sv | 24 ++
 rtl/ext_arb.sv | 150 +++++++++++++++
 tb/tb_ext_arb.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_pkg.sv
// Shared definitions for the immediate extender and its requester arbiter.
//   IMM_W / EXT_W     : immediate and extended-result widths
//   EOP_*             : extend-op encodings consumed by `ext`
//   ext_req_t         : immediate + op payload routed from the winning requester
//   slot_state_t      : occupancy of the arbiter's single result slot
package ext_pkg;

   localparam int unsigned IMM_W = 16;
   localparam int unsigned EXT_W = 32;

   localparam logic [1:0] EOP_SEXT     = 2'b00;
   localparam logic [1:0] EOP_ZEXT     = 2'b01;
   localparam logic [1:0] EOP_LUI      = 2'b10;
   localparam logic [1:0] EOP_SEXT_SL2 = 2'b11;

   typedef struct packed {
      logic [IMM_W-1:0] imm;
      logic [1:0]       eop;
   } ext_req_t;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

endpackage

// File: rtl/ext.sv
// Immediate extender (purely combinational).
//   imm : 16-bit immediate field
//   EOp : extend op (sign, zero, upper-half, sign-extend then shift left by 2)
//   ext : 32-bit extended value
module ext
   import ext_pkg::*;
(
   input  logic [IMM_W-1:0] imm,
   input  logic [1:0]       EOp,
   output logic [EXT_W-1:0] ext
);

   always_comb begin
      ext = '0;
      case (EOp)
         EOP_SEXT:     ext = {{(EXT_W-IMM_W){imm[IMM_W-1]}}, imm};
         EOP_ZEXT:     ext = {{(EXT_W-IMM_W){1'b0}}, imm};
         EOP_LUI:      ext = {imm, {(EXT_W-IMM_W){1'b0}}};
         EOP_SEXT_SL2: ext = {{(EXT_W-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
         default:      ext = '0;
      endcase
   end

endmodule

// File: rtl/ext_arb.sv
// Round-robin arbiter sharing one immediate extender among NREQ requesters,
// with a single registered result slot (1 result/cycle when drained).
//   clk, rst_n   : clock, asynchronous active-low reset
//   req_valid    : per-requester request
//   req_ready    : combinational one-hot acceptance pulse
//   req_imm      : immediate of requester i at [16*i +: 16]
//   req_eop      : extend op of requester i at [2*i +: 2]
//   out_valid    : result slot occupied
//   out_ready    : consumer takes the result
//   out_ext      : extended value
//   out_id       : requester that produced out_ext
// Optional (EXT_ARB_PERF_EN): perf_grants, perf_stalls 32-bit wrapping counters.
module ext_arb
   import ext_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [IMM_W*NREQ-1:0] req_imm,
   input  logic [2*NREQ-1:0]     req_eop,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [EXT_W-1:0]      out_ext,
   output logic [IDW-1:0]        out_id
`ifdef EXT_ARB_PERF_EN
   ,
   output logic [31:0]           perf_grants,
   output logic [31:0]           perf_stalls
`endif
);

   // First set request at or after ptr, wrapping past NREQ-1 to 0.
   function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                               input logic [IDW-1:0]  ptr);
      logic [IDW-1:0] pick;
      logic           found;
      pick  = '0;
      found = 1'b0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (!found && valid[i] && (IDW'(i) >= ptr)) begin
            found = 1'b1;
            pick  = IDW'(i);
         end
      end
      for (int i = 0; i < int'(NREQ); i++) begin
         if (!found && valid[i] && (IDW'(i) < ptr)) begin
            found = 1'b1;
            pick  = IDW'(i);
         end
      end
      return pick;
   endfunction

   slot_state_t       state, state_nxt;
   logic              can_accept;
   logic              grant;
   logic [IDW-1:0]    rr_ptr;
   logic [IDW-1:0]    winner;
   logic [IDW-1:0]    ptr_nxt;
   ext_req_t          sel;
   logic [EXT_W-1:0]  ext_val;

   assign winner = rr_pick(req_valid, rr_ptr);

   // Explicit modulo-NREQ wrap so non-power-of-2 NREQ works.
   assign ptr_nxt = (32'(winner) == NREQ - 1) ? '0 : winner + IDW'(1);

   // Slot state machine: next state and acceptance.
   always_comb begin
      state_nxt  = state;
      can_accept = 1'b0;
      grant      = 1'b0;
      case (state)
         SLOT_EMPTY: can_accept = 1'b1;
         SLOT_FULL:  can_accept = out_ready;
         default:    can_accept = 1'b0;
      endcase
      grant = can_accept && (|req_valid);
      if (grant)
         state_nxt = SLOT_FULL;
      else if ((state == SLOT_FULL) && out_ready)
         state_nxt = SLOT_EMPTY;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= SLOT_EMPTY;
      else        state <= state_nxt;
   end

   // One-hot acceptance pulse to the winner.
   always_comb begin
      req_ready = '0;
      for (int i = 0; i < int'(NREQ); i++)
         req_ready[i] = grant && (winner == IDW'(i));
   end

   // Route the winner's payload to the shared extender.
   always_comb begin
      sel = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (winner == IDW'(i)) begin
            sel.imm = req_imm[IMM_W*i +: IMM_W];
            sel.eop = req_eop[2*i +: 2];
         end
      end
   end

   ext u_ext (
      .imm (sel.imm),
      .EOp (sel.eop),
      .ext (ext_val)
   );

   // Result slot and round-robin pointer; data only moves on a grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_ext   <= '0;
         out_id    <= '0;
         rr_ptr    <= '0;
      end else begin
         out_valid <= (state_nxt == SLOT_FULL);
         if (grant) begin
            out_ext <= ext_val;
            out_id  <= winner;
            rr_ptr  <= ptr_nxt;
         end
      end
   end

`ifdef EXT_ARB_PERF_EN
   // Grant and stall counters, free-running with natural 32-bit wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_grants <= '0;
         perf_stalls <= '0;
      end else begin
         if (grant)
            perf_grants <= perf_grants + 32'd1;
         if ((|req_valid) && !grant)
            perf_stalls <= perf_stalls + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ext_arb.sv
// Directed bench for ext_arb: NREQ=4 instance checked every cycle against a
// behavioural model, plus a NREQ=3 instance for the wrap case.
module tb_ext_arb;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [63:0] req_imm;
   logic [7:0]  req_eop;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_ext;
   logic [1:0]  out_id;

   logic [2:0]  r3_valid;
   logic [2:0]  r3_ready;
   logic [47:0] r3_imm;
   logic [5:0]  r3_eop;
   logic        r3_out_valid;
   logic        r3_out_ready;
   logic [31:0] r3_out_ext;
   logic [1:0]  r3_out_id;

`ifdef EXT_ARB_PERF_EN
   logic [31:0] perf_grants, perf_stalls;
   logic [31:0] r3_perf_grants, r3_perf_stalls;
`endif

   int checks = 0;
   int errors = 0;

   ext_arb #(.NREQ(4), .IDW(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_imm(req_imm), .req_eop(req_eop),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_ext(out_ext), .out_id(out_id)
`ifdef EXT_ARB_PERF_EN
      , .perf_grants(perf_grants), .perf_stalls(perf_stalls)
`endif
   );

   ext_arb #(.NREQ(3), .IDW(2)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(r3_valid), .req_ready(r3_ready),
      .req_imm(r3_imm), .req_eop(r3_eop),
      .out_valid(r3_out_valid), .out_ready(r3_out_ready),
      .out_ext(r3_out_ext), .out_id(r3_out_id)
`ifdef EXT_ARB_PERF_EN
      , .perf_grants(r3_perf_grants), .perf_stalls(r3_perf_stalls)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model (NREQ=4 instance) ----------------
   function automatic logic [31:0] f_ext(input logic [15:0] imm, input logic [1:0] op);
      int sv;
      sv = imm[15] ? int'(imm) - 65536 : int'(imm);
      case (op)
         2'd0:    return 32'(sv);
         2'd1:    return 32'(int'(imm));
         2'd2:    return 32'(int'(imm) * 65536);
         default: return 32'(sv * 4);
      endcase
   endfunction

   function automatic int f_winner(input logic [3:0] v, input int ptr);
      for (int k = 0; k < 4; k++) begin
         int idx;
         idx = (ptr + k) % 4;
         if (((v >> idx) & 4'b0001) != 4'b0000) return idx;
      end
      return -1;
   endfunction

   logic        m_full   = 1'b0;
   logic [31:0] m_ext    = 32'h0;
   int          m_id     = 0;
   int          m_ptr    = 0;
   int          m_grants = 0;
   int          m_stalls = 0;
   int          mw;
   logic        mg;
   logic [3:0]  m_ready;

   always_comb begin
      mw      = f_winner(req_valid, m_ptr);
      mg      = (!m_full || out_ready) && (req_valid != 4'b0000);
      m_ready = (mg && mw >= 0) ? 4'(1 << mw) : 4'b0000;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_full   <= 1'b0;
         m_ext    <= 32'h0;
         m_id     <= 0;
         m_ptr    <= 0;
         m_grants <= 0;
         m_stalls <= 0;
      end else begin
         if (mg) begin
            m_full   <= 1'b1;
            m_ext    <= f_ext(req_imm[16*mw +: 16], req_eop[2*mw +: 2]);
            m_id     <= mw;
            m_ptr    <= (mw + 1) % 4;
            m_grants <= m_grants + 1;
         end else if (m_full && out_ready) begin
            m_full <= 1'b0;
         end
         if (req_valid != 4'b0000 && !mg)
            m_stalls <= m_stalls + 1;
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      check("model_req_ready", 32'(req_ready), 32'(m_ready));
      check("model_out_valid", 32'(out_valid), 32'(m_full));
      if (m_full) begin
         check("model_out_ext", out_ext, m_ext);
         check("model_out_id", 32'(out_id), 32'(m_id));
      end
`ifdef EXT_ARB_PERF_EN
      check("model_perf_grants", perf_grants, 32'(m_grants));
      check("model_perf_stalls", perf_stalls, 32'(m_stalls));
`endif
   end

   // ---------------- directed sequence ----------------
   logic [31:0] exp2 [4];

   initial begin
      exp2[0] = 32'hFFFF8001;
      exp2[1] = 32'h00008001;
      exp2[2] = 32'h80010000;
      exp2[3] = 32'hFFFE0004;

      rst_n = 1'b0;
      req_valid = '0; req_imm = '0; req_eop = '0; out_ready = 1'b0;
      r3_valid = '0; r3_imm = '0; r3_eop = '0; r3_out_ready = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_out_valid", 32'(out_valid), 32'h0);
      check("reset_out_ext", out_ext, 32'h0);
      check("reset_out_id", 32'(out_id), 32'h0);
      check("reset_req_ready", 32'(req_ready), 32'h0);

      // 1: single requester
      @(posedge clk); #2;
      rst_n = 1'b1;
      req_valid = 4'b0001; req_imm[15:0] = 16'h01f2; req_eop[1:0] = 2'b00; out_ready = 1'b1;
      @(negedge clk);
      check("t1_req_ready", 32'(req_ready), 32'h1);
      @(posedge clk); #1;
      check("t1_out_valid", 32'(out_valid), 32'h1);
      check("t1_out_ext", out_ext, 32'h000001f2);
      check("t1_out_id", 32'(out_id), 32'h0);
      #1;
      req_valid = 4'b0000;

      // 2: all four extend ops on requester 2
      req_imm[47:32] = 16'h8001;
      for (int e = 0; e < 4; e++) begin
         req_eop[5:4] = 2'(e);
         req_valid = 4'b0100;
         @(negedge clk);
         check("t2_req_ready", 32'(req_ready), 32'h4);
         @(posedge clk); #1;
         check("t2_out_ext", out_ext, exp2[e]);
         check("t2_out_id", 32'(out_id), 32'h2);
         #1;
      end
      req_valid = 4'b0000;

      // 3: fairness; first move rr_ptr to 0 with a lone requester 3
      req_valid = 4'b1000;
      @(negedge clk);
      check("t3_prime_ready", 32'(req_ready), 32'h8);
      @(posedge clk); #2;
      for (int i = 0; i < 4; i++) req_imm[16*i +: 16] = 16'h0100 + 16'(i);
      req_eop = 8'h55;
      req_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("t3_req_ready", 32'(req_ready), 32'(1 << (k % 4)));
         @(posedge clk); #1;
         check("t3_out_id", 32'(out_id), 32'(k % 4));
         check("t3_out_ext", out_ext, 32'h00000100 + 32'(k % 4));
         #1;
      end

      // 4: back-pressure with requester 1 waiting
      req_valid = 4'b0010; out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("t4_stall_ready", 32'(req_ready), 32'h0);
         check("t4_hold_valid", 32'(out_valid), 32'h1);
         check("t4_hold_id", 32'(out_id), 32'h0);
         check("t4_hold_ext", out_ext, 32'h00000100);
         @(posedge clk); #2;
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("t4_release_ready", 32'(req_ready), 32'h2);
      @(posedge clk); #1;
      check("t4_out_id", 32'(out_id), 32'h1);
      check("t4_out_ext", out_ext, 32'h00000101);
      #1;
      req_valid = 4'b0000;

      // 5: NREQ=3 wrap from rr_ptr=2
      r3_imm = {16'h0003, 16'h0002, 16'h0001};
      r3_eop = 6'b000000;
      r3_out_ready = 1'b1;
      r3_valid = 3'b010;
      @(negedge clk);
      check("t5_prime_ready", 32'(r3_ready), 32'h2);
      @(posedge clk); #2;
      r3_valid = 3'b011;
      @(negedge clk);
      check("t5_wrap_ready", 32'(r3_ready), 32'h1);
      @(posedge clk); #1;
      check("t5_wrap_id", 32'(r3_out_id), 32'h0);
      check("t5_wrap_ext", r3_out_ext, 32'h00000001);
      #1;
      @(negedge clk);
      check("t5_ptr1_ready", 32'(r3_ready), 32'h2);
      @(posedge clk); #1;
      check("t5_ptr1_id", 32'(r3_out_id), 32'h1);
      #1;
      r3_valid = 3'b000;

      // 6: async reset while FULL
      req_valid = 4'b0001; out_ready = 1'b0;
      @(posedge clk); #1;
      check("t6_full", 32'(out_valid), 32'h1);
      #2;
      rst_n = 1'b0;
      req_valid = 4'b0000;
      #1;
      check("t6_async_valid", 32'(out_valid), 32'h0);
      check("t6_async_ext", out_ext, 32'h0);
`ifdef EXT_ARB_PERF_EN
      check("t6_perf_grants", perf_grants, 32'h0);
      check("t6_perf_stalls", perf_stalls, 32'h0);
`endif
      @(posedge clk); #2;
      rst_n = 1'b1;
      req_valid = 4'b1010; out_ready = 1'b1;
      @(negedge clk);
      check("t6_rearb_ready", 32'(req_ready), 32'h2);
      @(posedge clk); #1;
      check("t6_rearb_id", 32'(out_id), 32'h1);
      #1;
      req_valid = 4'b0000;
      repeat (3) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
